mask_bbox_tracker: RTL and testbench
====================================

# mask_bbox_tracker

Consumes the denoised binary mask stream produced by the convolution/denoise kernel and reduces each frame to a single bounding box: minimum/maximum row and column of all set mask pixels plus a set-pixel count. Results are published once per frame on the vertical-sync falling edge. The box drives paddle position logic and the rectangle overlay in the augmented-reality pong pipeline.

## Interface
Parameters:
- LINE_WIDTH, 640, active columns; pixels with col_i >= LINE_WIDTH are ignored
- FRAME_HEIGHT, 480, active rows; pixels with row_i >= FRAME_HEIGHT are ignored
- CNT_W, 19, width of set-pixel counter (saturating)
- MIN_PIXELS, 16, minimum set-pixel count for a box to be declared valid

Ports (reset rstn, synchronous, active-low; clock clk):
- clk  in  1  pixel clock
- rstn  in  1  synchronous active-low reset
- vs_ni  in  1  vertical sync, active-low, aligned with mask_i
- valid_i  in  1  pixel qualifier from kernel
- mask_i  in  1  denoised mask bit (1 = object pixel)
- row_i  in  13  row of current pixel
- col_i  in  13  column of current pixel
- top_o  out  13  published minimum row
- bottom_o  out  13  published maximum row
- left_o  out  13  published minimum column
- right_o  out  13  published maximum column
- count_o  out  CNT_W  published set-pixel count
- box_valid_o  out  1  published box meets MIN_PIXELS
- frame_done_o  out  1  one-cycle pulse when outputs are updated

## Operation
- vs_q: registered copy of vs_ni (reset 1). Edge = vs_q & ~vs_ni.
- States: IDLE, ACCUM.
  - IDLE (reset state): accumulators held at clear values; on Edge -> ACCUM, no publish (first frame after reset is partial).
  - ACCUM: a pixel is counted iff valid_i & mask_i & vs_ni & row_i < FRAME_HEIGHT & col_i < LINE_WIDTH. Counted pixel: acc_top = min(acc_top,row_i), acc_bot = max(acc_bot,row_i), acc_left = min(acc_left,col_i), acc_right = max(acc_right,col_i), acc_cnt += 1 saturating at 2^CNT_W-1.
  - ACCUM on Edge: publish, clear accumulators, stay in ACCUM.
- Clear values: acc_top/acc_left = 13'h1FFF, acc_bot/acc_right = 0, acc_cnt = 0.
- Publish: count_o <= acc_cnt; frame_done_o <= 1. If acc_cnt >= MIN_PIXELS: box registers <= accumulators, box_valid_o <= 1. Otherwise box registers hold previous values, box_valid_o <= 0.
- Edge cycle pixel: vs_ni = 0, so never counted; accumulation of the new frame begins on the next qualifying pixel.
- Unsigned compares throughout; no wrap of 13-bit coordinates.

## Timing
- Reset values: top_o, bottom_o, left_o, right_o = 0; count_o = 0; box_valid_o = 0; frame_done_o = 0; state IDLE; vs_q = 1.
- Accumulator update: registered on the rising edge ending the pixel's cycle.
- Publish latency: Edge in cycle N -> outputs and frame_done_o valid in cycle N+1; frame_done_o low in N+2 unless another Edge.
- Outputs are stable between publishes.
- Reset mid-frame: all state cleared on the next clock; next Edge is treated as the first (no publish).
- vs_ni held low for many cycles: exactly one Edge, one publish.

## Configuration
- BBOX_SMOOTH_EN defined: when publishing a valid box and the previously published box_valid_o was 1, each box register <= (old + new) >> 1 using 14-bit sum, truncated. If previous box invalid, new values loaded directly. count_o unaffected.
- Undefined: box registers loaded directly with accumulator values.

## Test plan
- Reset, then two vs_ni falling edges with no mask pixels -> first edge: no frame_done_o; second: frame_done_o pulse, count_o = 0, box_valid_o = 0, box outputs 0.
- Frame with set pixels at (row,col) (100,200),(120,180),(110,250) + 13 at (105,210) -> top 100, bottom 120, left 180, right 250, count 16, box_valid_o = 1, one cycle after edge.
- Following frame with 5 set pixels -> count_o = 5, box_valid_o = 0, box outputs hold 100/120/180/250.
- Set pixels with valid_i = 0, col_i = 700, or row_i = 500 -> not counted.
- Assert rstn low mid-frame after 20 set pixels -> outputs 0; next edge no publish; following edge publishes only post-reset pixels.
- BBOX_SMOOTH_EN: valid box top 100 then valid box top 141 -> top_o = 120.

Source files
------------

// File: rtl/mask_bbox_tracker.sv
// mask_bbox_tracker
// Reduces each frame of the denoised binary mask stream to one bounding box
// (min/max row and column of set pixels) plus a saturating set-pixel count.
// Results are published once per frame, one cycle after the vs_ni falling edge.
// The first frame after reset is partial and is never published.
// Optional feature macro: BBOX_SMOOTH_EN -- when defined, a valid box is
// averaged with the previously published valid box instead of replacing it.
module mask_bbox_tracker #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int CNT_W        = 19,
  parameter int MIN_PIXELS   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vs_ni,
  input  logic              valid_i,
  input  logic              mask_i,
  input  logic [12:0]       row_i,
  input  logic [12:0]       col_i,
  output logic [12:0]       top_o,
  output logic [12:0]       bottom_o,
  output logic [12:0]       left_o,
  output logic [12:0]       right_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              box_valid_o,
  output logic              frame_done_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [12:0]      COORD_MAX = 13'h1FFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Average of two coordinates using a 14-bit sum so the carry is not lost.
  function automatic logic [12:0] avg13(input logic [12:0] a, input logic [12:0] b);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[13:1];
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_vs_q;
  logic             w_edge;
  logic             w_hit;
  logic             w_publish;
  logic             w_clear;
  logic             w_accum_en;
  logic             w_box_ok;

  logic [12:0]      r_acc_top;
  logic [12:0]      r_acc_bot;
  logic [12:0]      r_acc_left;
  logic [12:0]      r_acc_right;
  logic [CNT_W-1:0] r_acc_cnt;

  logic [12:0]      w_top_new;
  logic [12:0]      w_bot_new;
  logic [12:0]      w_left_new;
  logic [12:0]      w_right_new;

  // Falling edge of vertical sync, and the per-pixel qualification for counting.
  assign w_edge   = r_vs_q & ~vs_ni;
  assign w_hit    = valid_i & mask_i & vs_ni &
                    (row_i < 13'(FRAME_HEIGHT)) & (col_i < 13'(LINE_WIDTH));
  assign w_box_ok = (r_acc_cnt >= CNT_W'(MIN_PIXELS));

  // Registered copy of vertical sync for edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vs_q <= 1'b1;
    end else begin
      r_vs_q <= vs_ni;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and accumulator control: IDLE skips the partial first frame.
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_clear     = 1'b0;
    w_accum_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (w_edge) begin
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        w_state_nxt = ST_ACCUM;
        if (w_edge) begin
          w_publish = 1'b1;
          w_clear   = 1'b1;
        end else begin
          w_accum_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_clear     = 1'b1;
      end
    endcase
  end

  // Per-frame min/max/count accumulation of qualifying mask pixels.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc_top   <= COORD_MAX;
      r_acc_bot   <= 13'd0;
      r_acc_left  <= COORD_MAX;
      r_acc_right <= 13'd0;
      r_acc_cnt   <= {CNT_W{1'b0}};
    end else if (w_clear) begin
      r_acc_top   <= COORD_MAX;
      r_acc_bot   <= 13'd0;
      r_acc_left  <= COORD_MAX;
      r_acc_right <= 13'd0;
      r_acc_cnt   <= {CNT_W{1'b0}};
    end else if (w_accum_en && w_hit) begin
      r_acc_top   <= (row_i < r_acc_top)   ? row_i : r_acc_top;
      r_acc_bot   <= (row_i > r_acc_bot)   ? row_i : r_acc_bot;
      r_acc_left  <= (col_i < r_acc_left)  ? col_i : r_acc_left;
      r_acc_right <= (col_i > r_acc_right) ? col_i : r_acc_right;
      if (r_acc_cnt != CNT_MAX) begin
        r_acc_cnt <= r_acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Box values to load on a valid publish (optionally smoothed with the last box).
  always_comb begin
    w_top_new   = r_acc_top;
    w_bot_new   = r_acc_bot;
    w_left_new  = r_acc_left;
    w_right_new = r_acc_right;
`ifdef BBOX_SMOOTH_EN
    if (box_valid_o) begin
      w_top_new   = avg13(top_o,    r_acc_top);
      w_bot_new   = avg13(bottom_o, r_acc_bot);
      w_left_new  = avg13(left_o,   r_acc_left);
      w_right_new = avg13(right_o,  r_acc_right);
    end else begin
      w_top_new   = r_acc_top;
      w_bot_new   = r_acc_bot;
      w_left_new  = r_acc_left;
      w_right_new = r_acc_right;
    end
`else
    w_top_new   = r_acc_top;
    w_bot_new   = r_acc_bot;
    w_left_new  = r_acc_left;
    w_right_new = r_acc_right;
`endif
  end

  // Published outputs: updated only on publish; box held when too few pixels.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      top_o        <= 13'd0;
      bottom_o     <= 13'd0;
      left_o       <= 13'd0;
      right_o      <= 13'd0;
      count_o      <= {CNT_W{1'b0}};
      box_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= w_publish;
      if (w_publish) begin
        count_o <= r_acc_cnt;
        if (w_box_ok) begin
          top_o       <= w_top_new;
          bottom_o    <= w_bot_new;
          left_o      <= w_left_new;
          right_o     <= w_right_new;
          box_valid_o <= 1'b1;
        end else begin
          box_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Self-checking bench for mask_bbox_tracker: directed test-plan frames plus
// randomized frames, checked every cycle against a frame-level reference model
// that keeps the counted pixels of the current frame in queues.
module tb_mask_bbox_tracker;

  localparam int LW    = 640;
  localparam int FH    = 480;
  localparam int CNTW  = 19;
  localparam int MINPX = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic            vs_ni;
  logic            valid_i;
  logic            mask_i;
  logic [12:0]     row_i;
  logic [12:0]     col_i;
  logic [12:0]     top_o;
  logic [12:0]     bottom_o;
  logic [12:0]     left_o;
  logic [12:0]     right_o;
  logic [CNTW-1:0] count_o;
  logic            box_valid_o;
  logic            frame_done_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int q_row[$];
  int q_col[$];
  bit m_armed;
  bit m_vs_prev;
  int e_top, e_bot, e_left, e_right, e_cnt;
  bit e_valid, e_done;

  always #5 clk = ~clk;

  mask_bbox_tracker #(
    .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .CNT_W(CNTW), .MIN_PIXELS(MINPX)
  ) dut (
    .clk(clk), .rstn(rstn), .vs_ni(vs_ni), .valid_i(valid_i), .mask_i(mask_i),
    .row_i(row_i), .col_i(col_i), .top_o(top_o), .bottom_o(bottom_o),
    .left_o(left_o), .right_o(right_o), .count_o(count_o),
    .box_valid_o(box_valid_o), .frame_done_o(frame_done_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("frame_done", int'(frame_done_o), int'(e_done));
    chk("count",      int'(count_o),      e_cnt);
    chk("box_valid",  int'(box_valid_o),  int'(e_valid));
    chk("top",        int'(top_o),        e_top);
    chk("bottom",     int'(bottom_o),     e_bot);
    chk("left",       int'(left_o),       e_left);
    chk("right",      int'(right_o),      e_right);
  endtask

  // Frame summary from the list of counted pixels.
  task automatic publish();
    int t, b, l, r;
    t = 8191; b = 0; l = 8191; r = 0;
    foreach (q_row[i]) begin
      if (q_row[i] < t) t = q_row[i];
      if (q_row[i] > b) b = q_row[i];
      if (q_col[i] < l) l = q_col[i];
      if (q_col[i] > r) r = q_col[i];
    end
    e_cnt  = q_row.size();
    e_done = 1'b1;
    if (e_cnt >= MINPX) begin
`ifdef BBOX_SMOOTH_EN
      if (e_valid) begin
        t = (e_top + t) / 2;
        b = (e_bot + b) / 2;
        l = (e_left + l) / 2;
        r = (e_right + r) / 2;
      end
`endif
      e_top = t; e_bot = b; e_left = l; e_right = r;
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
  endtask

  // One pixel-clock cycle: drive inputs, clock, update model, compare.
  task automatic step(input bit vs, input bit v, input bit m, input int r, input int c);
    vs_ni = vs; valid_i = v; mask_i = m; row_i = 13'(r); col_i = 13'(c);
    @(posedge clk);
    #1;
    e_done = 1'b0;
    if (m_armed && v && m && vs && r < FH && c < LW) begin
      q_row.push_back(r);
      q_col.push_back(c);
    end
    if (m_vs_prev && !vs) begin
      if (m_armed) publish();
      q_row.delete();
      q_col.delete();
      m_armed = 1'b1;
    end
    m_vs_prev = vs;
    check_outputs();
  endtask

  task automatic pix(input int r, input int c);
    step(1'b1, 1'b1, 1'b1, r, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // vs_ni low for n cycles with random pixel activity, then a few idle cycles.
  task automatic vsync(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 300), $urandom_range(0, 300));
    idle(3);
  endtask

  task automatic do_reset();
    rstn = 1'b0; vs_ni = 1'b1; valid_i = 1'b0; mask_i = 1'b0;
    row_i = 13'd0; col_i = 13'd0;
    repeat (2) @(posedge clk);
    #1;
    q_row.delete(); q_col.delete();
    m_armed = 1'b0; m_vs_prev = 1'b1;
    e_top = 0; e_bot = 0; e_left = 0; e_right = 0; e_cnt = 0;
    e_valid = 1'b0; e_done = 1'b0;
    check_outputs();
    rstn = 1'b1;
  endtask

  task automatic random_frame();
    int n;
    n = $urandom_range(0, 40);
    for (int i = 0; i < n; i++) begin
      step(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
           $urandom_range(0, 520), $urandom_range(0, 700));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    vsync($urandom_range(1, 6));
  endtask

  initial begin
    do_reset();

    // Two empty frames: first edge arms only, second publishes an empty box.
    idle(4);
    vsync(3);
    idle(5);
    vsync(2);

    // Test-plan box of 16 pixels.
    pix(100, 200); pix(120, 180); pix(110, 250);
    for (int i = 0; i < 13; i++) pix(105, 210);
    vsync(1);

    // Too few pixels: box held, long vsync low gives a single publish.
    for (int i = 0; i < 5; i++) pix(300 + i, 400);
    vsync(20);

    // Ignored pixels, boundary coordinates, then enough to be valid.
    step(1'b1, 1'b0, 1'b1, 50, 50);
    step(1'b1, 1'b1, 1'b0, 50, 50);
    pix(50, 700); pix(500, 50); pix(480, 10); pix(10, 640);
    pix(479, 639); pix(0, 0);
    for (int i = 0; i < 14; i++) pix(200, 300 + i);
    vsync(2);

    // Mid-frame reset after 20 pixels.
    for (int i = 0; i < 20; i++) pix(60, 60 + i);
    do_reset();
    for (int i = 0; i < 8; i++) pix(70, 70);
    vsync(2);
    for (int i = 0; i < 17; i++) pix(80 + i, 90);
    vsync(2);

    // Consecutive valid boxes (top 100 then top 141).
    for (int i = 0; i < 16; i++) pix(100 + i, 300);
    vsync(1);
    for (int i = 0; i < 16; i++) pix(141, 300 + i);
    vsync(1);

    // Randomized frames.
    for (int f = 0; f < 40; f++) random_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
